mem_stage: RTL and testbench

//  Memory-access stage of the 5-stage LoongArch pipeline, between exe_stage and wb_stage.

---
 rtl/mem_stage.sv | 171 +++++++++++++++++
 tb/tb_mem_stage.sv | 333 +++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/mem_stage.sv
// mem_stage: memory-access stage of the 5-stage LoongArch pipeline.
// Holds one EXE->MEM entry, waits for the in-order data_ok of the request EXE
// already issued, aligns/extends load data, forwards a hazard bus to decode and
// passes exception/CSR fields on to writeback. Responses whose owner was
// flushed are counted and dropped when they arrive.
// Build option: define MS_DATA_OK_BYPASS_EN to let data_ok complete the entry in
// the same cycle (load data flows combinationally from data_sram_rdata).
// Without it every response is buffered first, costing one extra cycle.
module mem_stage #(
  parameter int ES_TO_MS_BUS_WD = 164,
  parameter int MS_TO_WS_BUS_WD = 157,
  parameter int MS_TO_DS_BUS_WD = 54,
  parameter int DISCARD_CNT_W   = 2
) (
  input  logic                       clk,
  input  logic                       resetn,
  input  logic                       ws_allowin,
  output logic                       ms_allowin,
  input  logic                       es_to_ms_valid,
  input  logic [ES_TO_MS_BUS_WD-1:0] es_to_ms_bus,
  output logic                       ms_to_ws_valid,
  output logic [MS_TO_WS_BUS_WD-1:0] ms_to_ws_bus,
  output logic [MS_TO_DS_BUS_WD-1:0] ms_to_ds_bus,
  output logic                       ms_ex_int,
  input  logic                       ws_block,
  input  logic                       data_sram_data_ok,
  input  logic [31:0]                data_sram_rdata
);

  localparam logic [DISCARD_CNT_W-1:0] CNT_MAX = '1;

  // State
  logic                       ms_valid_q, ms_valid_d;
  logic [ES_TO_MS_BUS_WD-1:0] bus_q, bus_d;
  logic                       buf_valid_q, buf_valid_d;
  logic [31:0]                buf_data_q, buf_data_d;
  logic [DISCARD_CNT_W-1:0]   discard_cnt_q, discard_cnt_d;

  // Fields of the latched entry
  logic        mem_exce, csr_we, res_from_mem, mem_we, gr_we;
  logic [13:0] csr_num;
  logic [4:0]  ld_inst, dest;
  logic [31:0] result, pc;

  assign mem_exce     = bus_q[160];
  assign csr_num      = bus_q[155:142];
  assign csr_we       = bus_q[141];
  assign ld_inst      = bus_q[76:72];   // {hu, bu, h, b, w}
  assign res_from_mem = bus_q[71];
  assign mem_we       = bus_q[70];
  assign gr_we        = bus_q[69];
  assign dest         = bus_q[68:64];
  assign result       = bus_q[63:32];
  assign pc           = bus_q[31:0];

  // Handshake and response bookkeeping
  logic need_data, rsp_ok, waiting, ms_ready_go, ms_leave;
  logic discard_inc, discard_dec;
  logic ms_loading;
  logic [31:0] load_raw, byte_shift, half_shift, load_data, ms_final_result;

  assign need_data = (res_from_mem | mem_we) & ~mem_exce;
  assign rsp_ok    = data_sram_data_ok & (discard_cnt_q == '0);
  assign waiting   = ms_valid_q & need_data & ~buf_valid_q;

`ifdef MS_DATA_OK_BYPASS_EN
  assign ms_ready_go = ~need_data | buf_valid_q | rsp_ok;
  assign load_raw    = buf_valid_q ? buf_data_q : data_sram_rdata;
`else
  assign ms_ready_go = ~need_data | buf_valid_q;
  assign load_raw    = buf_data_q;
`endif

  assign ms_allowin     = ~ms_valid_q | (ms_ready_go & ws_allowin);
  assign ms_to_ws_valid = ms_valid_q & ms_ready_go;
  assign ms_leave       = ms_to_ws_valid & ws_allowin;
  assign ms_loading     = ms_valid_q & res_from_mem & ~ms_ready_go;
  assign ms_ex_int      = ms_valid_q & (|bus_q[163:156]);

  // A flushed waiter whose response has not arrived leaves an orphan behind; any
  // data_ok seen while orphans are outstanding belongs to one of them.
  assign discard_inc = ws_block & waiting & ~rsp_ok;
  assign discard_dec = data_sram_data_ok & (discard_cnt_q != '0);

  // Entry valid bit and payload capture.
  always_comb begin
    // NOTE: every variable gets its default first so no path leaves it unassigned (no latch).
    ms_valid_d = ms_valid_q;
    bus_d      = bus_q;
    if (ws_block) begin
      ms_valid_d = 1'b0;
    end else if (ms_allowin) begin
      ms_valid_d = es_to_ms_valid;
    end
    if (es_to_ms_valid && ms_allowin) begin
      bus_d = es_to_ms_bus;
    end
  end

  // Response buffer: hold data_ok payload until the entry can leave.
  always_comb begin
    buf_valid_d = buf_valid_q;
    buf_data_d  = buf_data_q;
    if (ws_block || ms_leave) begin
      buf_valid_d = 1'b0;
    end else if (waiting && rsp_ok) begin
      buf_valid_d = 1'b1;
      buf_data_d  = data_sram_rdata;
    end
  end

  // Orphan-response counter; a flush and a drop in the same cycle cancel out.
  always_comb begin
    discard_cnt_d = discard_cnt_q;
    if (discard_inc && !discard_dec) begin
      if (discard_cnt_q != CNT_MAX) begin
        discard_cnt_d = discard_cnt_q + DISCARD_CNT_W'(1);
      end
    end else if (discard_dec && !discard_inc) begin
      discard_cnt_d = discard_cnt_q - DISCARD_CNT_W'(1);
    end
  end

  // Load alignment and sign/zero extension.
  always_comb begin
    byte_shift = load_raw >> {result[1:0], 3'b000};
    half_shift = load_raw >> {result[1], 4'b0000};
    if (ld_inst[1]) begin
      load_data = {{24{byte_shift[7]}}, byte_shift[7:0]};
    end else if (ld_inst[3]) begin
      load_data = {24'd0, byte_shift[7:0]};
    end else if (ld_inst[2]) begin
      load_data = {{16{half_shift[15]}}, half_shift[15:0]};
    end else if (ld_inst[4]) begin
      load_data = {16'd0, half_shift[15:0]};
    end else begin
      load_data = load_raw;
    end
    ms_final_result = res_from_mem ? load_data : result;
  end

  // Control state: cleared asynchronously so a reset mid-transaction drops everything.
  always_ff @(posedge clk or negedge resetn) begin
    // NOTE: sequential state uses non-blocking assignments so all flops update together.
    if (!resetn) begin
      ms_valid_q    <= 1'b0;
      buf_valid_q   <= 1'b0;
      discard_cnt_q <= '0;
    end else begin
      ms_valid_q    <= ms_valid_d;
      buf_valid_q   <= buf_valid_d;
      discard_cnt_q <= discard_cnt_d;
    end
  end

  // Payload registers: only read while the matching valid flag is set.
  always_ff @(posedge clk) begin
    // NOTE: datapath payload is deliberately not reset; valid flags qualify every use.
    bus_q      <= bus_d;
    buf_data_q <= buf_data_d;
  end

  assign ms_to_ws_bus = {bus_q[163:77], gr_we, dest, ms_final_result, pc};
  assign ms_to_ds_bus = {csr_we & ms_valid_q, csr_num, gr_we & ms_valid_q, dest,
                         ms_final_result, ms_loading};

  // More outstanding orphans than the counter can hold would misroute responses.
  a_discard_no_sat: assert property (@(posedge clk) disable iff (!resetn)
    !(discard_inc && !discard_dec && discard_cnt_q == CNT_MAX));

endmodule

// File: tb/tb_mem_stage.sv
// tb_mem_stage: scoreboard bench for mem_stage. A driver issues entries and a
// memory model answers them in order; expected writeback buses are queued at
// issue and a monitor compares them whenever an entry leaves MEM.
`timescale 1ns/1ps
module tb_mem_stage;

`ifdef MS_DATA_OK_BYPASS_EN
  localparam int EXP_GAP = 1;
`else
  localparam int EXP_GAP = 2;
`endif

  logic         clk = 1'b0;
  logic         resetn, ws_allowin, ms_allowin, es_to_ms_valid;
  logic         ms_to_ws_valid, ms_ex_int, ws_block, data_ok;
  logic [163:0] es_bus;
  logic [156:0] ws_bus;
  logic [53:0]  ds_bus;
  logic [31:0]  rdata;

  always #5 clk = ~clk;

  mem_stage dut (
    .clk               (clk),
    .resetn            (resetn),
    .ws_allowin        (ws_allowin),
    .ms_allowin        (ms_allowin),
    .es_to_ms_valid    (es_to_ms_valid),
    .es_to_ms_bus      (es_bus),
    .ms_to_ws_valid    (ms_to_ws_valid),
    .ms_to_ws_bus      (ws_bus),
    .ms_to_ds_bus      (ds_bus),
    .ms_ex_int         (ms_ex_int),
    .ws_block          (ws_block),
    .data_sram_data_ok (data_ok),
    .data_sram_rdata   (rdata)
  );

  typedef struct { logic [31:0] data; int ready; } mem_rsp_t;

  int           n_checks = 0;
  int           n_err = 0;
  int           cyc = 0;
  int           allow_mode = 0;  // 0 open, 1 random, 2 driven by the test
  int           last_ready;
  mem_rsp_t     mem_q[$];
  logic [156:0] sb_q[$];
  int           leave_cyc[$];

  localparam logic [4:0] LD_W = 5'b00001, LD_B = 5'b00010, LD_H = 5'b00100,
                         LD_BU = 5'b01000, LD_HU = 5'b10000;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input logic [156:0] act, input logic [156:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h, expected %h", name, act, exp);
    end
  endtask

  function automatic logic [163:0] mk_bus(input logic [7:0] exc, input logic [4:0] ld,
                                          input logic rfm, input logic mw, input logic gw,
                                          input logic [31:0] res);
    logic [13:0] cnum;
    logic [31:0] cwd, cwm, pc;
    logic [4:0]  dst;
    logic        cwe;
    cnum = 14'($urandom); cwd = $urandom; cwm = $urandom; pc = $urandom;
    dst = 5'($urandom); cwe = 1'($urandom);
    return {exc, cnum, cwe, cwd, cwm, ld, rfm, mw, gw, dst, res, pc};
  endfunction

  // Reference load semantics: pick the addressed byte/half, then extend.
  function automatic logic [31:0] model_load(input logic [4:0] ld, input logic [1:0] a,
                                             input logic [31:0] d);
    logic [31:0] byt, half;
    byt  = (d >> (8 * a)) & 32'hFF;
    half = (d >> (16 * a[1])) & 32'hFFFF;
    case (ld)
      LD_B:    return (byt >= 128) ? byt + 32'hFFFF_FF00 : byt;
      LD_BU:   return byt;
      LD_H:    return (half >= 32768) ? half + 32'hFFFF_0000 : half;
      LD_HU:   return half;
      default: return d;
    endcase
  endfunction

  // Memory side: answers queued requests in order, never before their ready cycle.
  initial begin
    data_ok = 1'b0;
    rdata   = '0;
    forever begin
      @(posedge clk); #1;
      if (mem_q.size() > 0 && cyc >= mem_q[0].ready) begin
        data_ok = 1'b1;
        rdata   = mem_q[0].data;
        void'(mem_q.pop_front());
      end else begin
        data_ok = 1'b0;
        rdata   = $urandom;
      end
    end
  end

  // Writeback back-pressure generator.
  initial begin
    forever begin
      @(posedge clk); #1;
      if (allow_mode == 0) ws_allowin = 1'b1;
      else if (allow_mode == 1) ws_allowin = ($urandom_range(0, 3) != 0);
    end
  end

  // Monitor: every entry accepted by writeback is checked against the scoreboard.
  initial begin
    logic [156:0] e;
    forever begin
      @(negedge clk);
      if (resetn && ms_to_ws_valid && ws_allowin) begin
        leave_cyc.push_back(cyc);
        if (sb_q.size() == 0) begin
          n_checks++;
          n_err++;
          $display("FAIL unexpected_output: got bus %h, expected no output", ws_bus);
        end else begin
          e = sb_q.pop_front();
          check("ws_bus", ws_bus, e);
          check("ex_int", 157'(ms_ex_int), 157'(|e[156:149]));
          check("ds_bus", 157'(ds_bus), 157'({e[134], e[148:135], e[69], e[68:64], e[63:32], 1'b0}));
        end
      end
    end
  end

  // Present one entry to MEM and record its expected writeback bus and memory reply.
  task automatic issue(input logic [163:0] b, input logic [31:0] mem_data, input int delay,
                       input logic [31:0] exp_final);
    int  guard = 0;
    bit  ok = 1'b0;
    es_to_ms_valid = 1'b1;
    es_bus = b;
    while (!ok && guard < 100) begin
      @(negedge clk);
      if (ms_allowin) ok = 1'b1;
      else begin
        guard++;
        @(posedge clk); #1;
      end
    end
    if (!ok) begin
      n_checks++;
      n_err++;
      $display("FAIL accept_timeout: ms_allowin got 0 for 100 cycles, expected 1");
    end else begin
      if ((b[71] | b[70]) & ~b[160]) begin
        last_ready = cyc + 1 + delay;
        mem_q.push_back('{data: mem_data, ready: last_ready});
      end
      sb_q.push_back({b[163:77], b[69], b[68:64], exp_final, b[31:0]});
      @(posedge clk); #1;
    end
    es_to_ms_valid = 1'b0;
  endtask

  task automatic do_reset();
    resetn = 1'b0;
    mem_q.delete();
    sb_q.delete();
    @(posedge clk); #1;
    resetn = 1'b1;
    @(posedge clk); #1;
  endtask

  task automatic drain();
    int n = 0;
    while (sb_q.size() != 0 && n < 200) begin
      @(negedge clk);
      n++;
    end
    n_checks++;
    if (sb_q.size() != 0) begin
      n_err++;
      $display("FAIL drain: %0d entries still pending, expected 0", sb_q.size());
      do_reset();
    end else begin
      @(posedge clk); #1;
    end
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [163:0] b;
    logic [31:0]  d;
    logic [4:0]   ld;
    logic [7:0]   exc;
    int           kind;

    resetn = 1'b0; es_to_ms_valid = 1'b0; es_bus = '0; ws_block = 1'b0; ws_allowin = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    check("rst_allowin", 157'(ms_allowin), 157'(1));
    check("rst_ws_valid", 157'(ms_to_ws_valid), 157'(0));
    check("rst_ex_int", 157'(ms_ex_int), 157'(0));
    check("rst_ds_flags", 157'({ds_bus[53], ds_bus[38], ds_bus[0]}), 157'(0));
    resetn = 1'b1;
    @(posedge clk); #1;

    // Byte and half loads with fixed data.
    issue(mk_bus(8'h0, LD_B,  1, 0, 1, 32'h1000_0003), 32'h80FF_1234, 0, 32'hFFFF_FF80);
    issue(mk_bus(8'h0, LD_BU, 1, 0, 1, 32'h1000_0003), 32'h80FF_1234, 0, 32'h0000_0080);
    issue(mk_bus(8'h0, LD_H,  1, 0, 1, 32'h2000_0002), 32'h8001_7FFF, 1, 32'hFFFF_8001);
    issue(mk_bus(8'h0, LD_HU, 1, 0, 1, 32'h2000_0002), 32'h8001_7FFF, 0, 32'h0000_8001);
    issue(mk_bus(8'h0, LD_W,  1, 0, 1, 32'h2000_0000), 32'h8001_7FFF, 2, 32'h8001_7FFF);
    drain();

    // Response arrives while writeback is stalled: result must be held from the buffer.
    allow_mode = 2; ws_allowin = 1'b0;
    issue(mk_bus(8'h0, LD_W, 1, 0, 1, 32'h3000_0000), 32'h1234_5678, 0, 32'h1234_5678);
    for (int i = 0; i < 3; i++) begin
      @(posedge clk); #1;
      @(negedge clk);
      check("stall_valid", 157'(ms_to_ws_valid), 157'(1));
      check("stall_result", 157'(ws_bus[63:32]), 157'(32'h1234_5678));
      check("stall_loading", 157'(ds_bus[0]), 157'(0));
    end
    @(posedge clk); #1;
    allow_mode = 0; ws_allowin = 1'b1;
    drain();

    // Flush a waiting load; its late response must be dropped, not given to the next load.
    issue(mk_bus(8'h0, LD_W, 1, 0, 1, 32'h4000_0000), 32'hAAAA_0001, 6, 32'hAAAA_0001);
    @(negedge clk);
    check("wait_loading", 157'(ds_bus[0]), 157'(1));
    check("wait_valid", 157'(ms_to_ws_valid), 157'(0));
    @(posedge clk); #1;
    ws_block = 1'b1;
    void'(sb_q.pop_back());
    @(posedge clk); #1;
    ws_block = 1'b0;
    @(negedge clk);
    check("flush_valid", 157'(ms_to_ws_valid), 157'(0));
    check("flush_allowin", 157'(ms_allowin), 157'(1));
    check("flush_gr_we", 157'(ds_bus[38]), 157'(0));
    @(posedge clk); #1;
    issue(mk_bus(8'h0, LD_W, 1, 0, 1, 32'h4000_0004), 32'hBBBB_0002, 0, 32'hBBBB_0002);
    drain();

    // Flush in the very cycle the response arrives: nothing is left to discard.
    allow_mode = 2; ws_allowin = 1'b0;
    issue(mk_bus(8'h0, LD_W, 1, 0, 1, 32'h5000_0000), 32'hCCCC_0003, 2, 32'hCCCC_0003);
    while (cyc < last_ready) begin
      @(posedge clk); #1;
    end
    ws_block = 1'b1;
    void'(sb_q.pop_back());
    @(posedge clk); #1;
    ws_block = 1'b0;
    allow_mode = 0; ws_allowin = 1'b1;
    issue(mk_bus(8'h0, LD_W, 1, 0, 1, 32'h5000_0004), 32'hDDDD_0004, 1, 32'hDDDD_0004);
    drain();

    // Store with a memory exception and syscall: no data wait at all.
    issue(mk_bus(8'h11, 5'b0, 0, 1, 0, 32'h6000_0000), 32'h0, 0, 32'h6000_0000);
    @(negedge clk);
    check("exc_valid", 157'(ms_to_ws_valid), 157'(1));
    check("exc_ex_int", 157'(ms_ex_int), 157'(1));
    drain();

    // Back-to-back word loads answered one cycle after entry.
    leave_cyc.delete();
    for (int i = 0; i < 4; i++) begin
      d = $urandom;
      issue(mk_bus(8'h0, LD_W, 1, 0, 1, 32'h7000_0000 + 32'(4 * i)), d, 0, d);
    end
    drain();
    n_checks++;
    if (leave_cyc.size() != 4) begin
      n_err++;
      $display("FAIL b2b_count: got %0d leaves, expected 4", leave_cyc.size());
    end else begin
      for (int i = 0; i < 3; i++)
        check("b2b_gap", 157'(leave_cyc[i+1] - leave_cyc[i]), 157'(EXP_GAP));
    end

    // Randomized traffic with back-pressure and variable memory latency.
    allow_mode = 1;
    for (int n = 0; n < 300; n++) begin
      kind = $urandom_range(0, 9);
      exc  = ($urandom_range(0, 6) == 0) ? 8'($urandom) : 8'h0;
      d    = $urandom;
      if (kind <= 4) begin
        ld  = 5'b1 << kind;
        exc[4] = 1'b0;
        b = mk_bus(exc, ld, 1, 0, 1'($urandom), $urandom);
        issue(b, d, $urandom_range(0, 3), model_load(ld, b[33:32], d));
      end else begin
        b = mk_bus(exc, 5'b0, 0, (kind <= 6), 1'($urandom), $urandom);
        issue(b, d, $urandom_range(0, 3), b[63:32]);
      end
      repeat ($urandom_range(0, 2)) begin
        @(posedge clk); #1;
      end
    end
    allow_mode = 0;
    drain();

    // Reset while a load waits: state clears immediately.
    issue(mk_bus(8'h0, LD_W, 1, 0, 1, 32'h8000_0000), 32'hEEEE_0005, 8, 32'hEEEE_0005);
    resetn = 1'b0;
    mem_q.delete();
    sb_q.delete();
    #1;
    check("mid_rst_valid", 157'(ms_to_ws_valid), 157'(0));
    check("mid_rst_allowin", 157'(ms_allowin), 157'(1));
    check("mid_rst_loading", 157'(ds_bus[0]), 157'(0));
    @(posedge clk); #1;
    resetn = 1'b1;
    @(posedge clk); #1;
    issue(mk_bus(8'h0, LD_W, 1, 0, 1, 32'h8000_0004), 32'h0F0F_0006, 1, 32'h0F0F_0006);
    drain();

    $display("Result: errors=%0d of %0d checks", n_err, n_checks);
    $finish;
  end

endmodule
